// File: rtl/sdram_refresh_scheduler_pkg.sv
// rtl/sdram_refresh_scheduler_pkg.sv - shared SDRAM command and init FSM encodings
package sdram_refresh_scheduler_pkg;

    // Command codes presented on cmd_o
    typedef enum logic [1:0] {
        CMD_NOP           = 2'b00,
        CMD_PRECHARGE_ALL = 2'b01,
        CMD_AUTO_REFRESH  = 2'b10,
        CMD_LOAD_MODE     = 2'b11
    } sdram_cmd_e;

    // Init sequencer states; RUN is terminal until reset
    typedef enum logic [2:0] {
        ST_WAIT_POWERUP = 3'd0,
        ST_PRECHARGE    = 3'd1,
        ST_WAIT_TRP     = 3'd2,
        ST_REFRESH      = 3'd3,
        ST_WAIT_TRFC    = 3'd4,
        ST_LOAD_MODE    = 3'd5,
        ST_WAIT_TMRD    = 3'd6,
        ST_RUN          = 3'd7
    } init_state_e;

    localparam int unsigned PENDING_W   = 3;
    localparam logic [PENDING_W-1:0] PENDING_MAX = 3'd7;

    // Command issued while sitting in a given state; wait states issue NOP
    function automatic sdram_cmd_e cmd_for_state(input init_state_e st);
        case (st)
            ST_PRECHARGE: return CMD_PRECHARGE_ALL;
            ST_REFRESH:   return CMD_AUTO_REFRESH;
            ST_LOAD_MODE: return CMD_LOAD_MODE;
            default:      return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sync_parallel_counter.sv
// rtl/sync_parallel_counter.sv - up/down counter with separate increment and decrement enables
module sync_parallel_counter #(
    parameter int unsigned SIZE = 3,
    parameter logic [SIZE-1:0] INIT_VALUE = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_en_i,
    input  logic            dec_en_i,
    output logic [SIZE-1:0] count_o
);

    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;

    // Simultaneous inc and dec cancel; wrap protection is the caller's job
    always_comb begin
        count_d = count_q;
        if (inc_en_i && !dec_en_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_en_i && !inc_en_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= INIT_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// rtl/sdram_refresh_scheduler.sv - SDRAM power-up init sequencer and periodic refresh scheduler
module sdram_refresh_scheduler
    import sdram_refresh_scheduler_pkg::*;
#(
    parameter int unsigned INIT_CYCLES      = 20000,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RFC            = 7,
    parameter int unsigned T_MRD            = 2,
    parameter int unsigned INIT_REFRESHES   = 8,
    parameter int unsigned REFRESH_INTERVAL = 780,
    parameter int unsigned URGENT_LEVEL     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 refresh_ack_i,
    output logic [1:0]           cmd_o,
    output logic                 cmd_valid_o,
    output logic                 init_done_o,
    output logic                 refresh_req_o,
    output logic                 refresh_urgent_o,
    output logic [PENDING_W-1:0] pending_o,
    output logic                 overflow_o
);

    init_state_e          state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;     // wait counter during init, interval counter in RUN
    logic [31:0]          ref_q, ref_d;     // init AUTO_REFRESH commands issued so far
    logic                 overflow_q, overflow_d;
    logic                 tick;
    logic                 run;
    logic                 ack_eff;
    logic                 saturated;
    logic                 inc_en;
    logic                 dec_en;
    logic [PENDING_W-1:0] pending_q;

    assign run = (state_q == ST_RUN);

    // Init sequencing and the RUN-phase refresh interval timer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        ref_d   = ref_q;
        tick    = 1'b0;
        case (state_q)
            ST_WAIT_POWERUP: begin
                if (cnt_q == INIT_CYCLES - 32'd1) begin
                    state_d = ST_PRECHARGE;
                    cnt_d   = '0;
                end
            end
            ST_PRECHARGE: begin
                state_d = ST_WAIT_TRP;
                cnt_d   = '0;
            end
            ST_WAIT_TRP: begin
                if (cnt_q == T_RP - 32'd1) begin
                    state_d = ST_REFRESH;
                    cnt_d   = '0;
                end
            end
            ST_REFRESH: begin
                state_d = ST_WAIT_TRFC;
                cnt_d   = '0;
                ref_d   = ref_q + 32'd1;
            end
            ST_WAIT_TRFC: begin
                if (cnt_q == T_RFC - 32'd1) begin
                    cnt_d   = '0;
                    state_d = (ref_q >= INIT_REFRESHES) ? ST_LOAD_MODE : ST_REFRESH;
                end
            end
            ST_LOAD_MODE: begin
                state_d = ST_WAIT_TMRD;
                cnt_d   = '0;
            end
            ST_WAIT_TMRD: begin
                if (cnt_q == T_MRD - 32'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == REFRESH_INTERVAL - 32'd1) begin
                    tick  = 1'b1;
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counters and sticky overflow registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_WAIT_POWERUP;
            cnt_q      <= '0;
            ref_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            overflow_q <= overflow_d;
        end
    end

    // Acks only count against real pending work once running; a tick at
    // the ceiling with no ack to absorb it is lost and recorded
    always_comb begin
        ack_eff    = refresh_ack_i && run && (pending_q != '0);
        saturated  = (pending_q == PENDING_MAX);
        inc_en     = tick && !ack_eff && !saturated;
        dec_en     = ack_eff && !tick;
        overflow_d = overflow_q || (tick && !ack_eff && saturated);
    end

    sync_parallel_counter #(
        .SIZE       (PENDING_W),
        .INIT_VALUE (3'd0)
    ) u_pending_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_en_i (inc_en),
        .dec_en_i (dec_en),
        .count_o  (pending_q)
    );

    assign cmd_o            = cmd_for_state(state_q);
    assign cmd_valid_o      = (state_q == ST_PRECHARGE) || (state_q == ST_REFRESH) ||
                              (state_q == ST_LOAD_MODE);
    assign init_done_o      = run;
    assign pending_o        = pending_q;
    assign refresh_req_o    = (pending_q != '0);
    assign refresh_urgent_o = (32'(pending_q) >= URGENT_LEVEL);
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// tb/tb_sdram_refresh_scheduler.sv - directed and random checks of the refresh scheduler
module tb_sdram_refresh_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ack;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       init_done;
    logic       refresh_req;
    logic       refresh_urgent;
    logic [2:0] pending;
    logic       overflow;

    int vectors;
    int miscompares;
    int cyc;

    sdram_refresh_scheduler #(
        .INIT_CYCLES      (10),
        .T_RP             (2),
        .T_RFC            (4),
        .T_MRD            (2),
        .INIT_REFRESHES   (2),
        .REFRESH_INTERVAL (8),
        .URGENT_LEVEL     (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .refresh_ack_i    (ack),
        .cmd_o            (cmd),
        .cmd_valid_o      (cmd_valid),
        .init_done_o      (init_done),
        .refresh_req_o    (refresh_req),
        .refresh_urgent_o (refresh_urgent),
        .pending_o        (pending),
        .overflow_o       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the middle of the next cycle
    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    // Hold reset for a few cycles, release just after a rising edge; cycle 0 sampled next
    task automatic reset_and_release();
        rst_n = 1'b0;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = -1;
        step();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack   = 1'b0;
        repeat (2) @(negedge clk);
        vectors = vectors + 7;
        if (cmd !== 2'b00) begin miscompares++; $display("FAIL reset_cmd got %b want 00", cmd); end
        if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", init_done); end
        if (refresh_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", refresh_req); end
        if (refresh_urgent !== 1'b0) begin miscompares++; $display("FAIL reset_urgent got %b want 0", refresh_urgent); end
        if (pending !== 3'd0) begin miscompares++; $display("FAIL reset_pending got %0d want 0", pending); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    // Checks cmd/cmd_valid/init_done/pending against the documented init timeline
    task automatic test_init_sequence(input int last_cycle);
        logic       ev;
        logic [1:0] ec;
        logic       ed;
        while (cyc <= last_cycle) begin
            ev = (cyc == 10) || (cyc == 13) || (cyc == 18) || (cyc == 23);
            ec = (cyc == 10) ? 2'b01 : ((cyc == 13) || (cyc == 18)) ? 2'b10 :
                 (cyc == 23) ? 2'b11 : 2'b00;
            ed = (cyc >= 26);
            vectors = vectors + 4;
            if (cmd_valid !== ev) begin miscompares++; $display("FAIL init_cmd_valid cyc %0d got %b want %b", cyc, cmd_valid, ev); end
            if (cmd !== ec) begin miscompares++; $display("FAIL init_cmd cyc %0d got %b want %b", cyc, cmd, ec); end
            if (init_done !== ed) begin miscompares++; $display("FAIL init_done cyc %0d got %b want %b", cyc, init_done, ed); end
            if (pending !== 3'd0) begin miscompares++; $display("FAIL init_pending cyc %0d got %0d want 0", cyc, pending); end
            step();
        end
    endtask

    // No acks: pending climbs once per 8 clocks from cycle 34, saturates at 7, overflow at 90
    task automatic test_saturation();
        logic [2:0] ep;
        int         n;
        reset_and_release();
        run_to(26);
        while (cyc <= 100) begin
            n  = (cyc < 34) ? 0 : (cyc - 26) / 8;
            ep = (n > 7) ? 3'd7 : 3'(n);
            vectors = vectors + 5;
            if (pending !== ep) begin miscompares++; $display("FAIL sat_pending cyc %0d got %0d want %0d", cyc, pending, ep); end
            if (refresh_req !== (ep != 3'd0)) begin miscompares++; $display("FAIL sat_req cyc %0d got %b want %b", cyc, refresh_req, ep != 3'd0); end
            if (refresh_urgent !== (ep >= 3'd4)) begin miscompares++; $display("FAIL sat_urgent cyc %0d got %b want %b", cyc, refresh_urgent, ep >= 3'd4); end
            if (overflow !== (cyc >= 90)) begin miscompares++; $display("FAIL sat_overflow cyc %0d got %b want %b", cyc, overflow, cyc >= 90); end
            if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL run_cmd_valid cyc %0d got %b want 0", cyc, cmd_valid); end
            step();
        end
        // Reset while running with a saturated, overflowed counter
        #1 rst_n = 1'b0;
        #1;
        vectors = vectors + 4;
        if (pending !== 3'd0) begin miscompares++; $display("FAIL runrst_pending got %0d want 0", pending); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL runrst_overflow got %b want 0", overflow); end
        if (init_done !== 1'b0) begin miscompares++; $display("FAIL runrst_init_done got %b want 0", init_done); end
        if (refresh_urgent !== 1'b0) begin miscompares++; $display("FAIL runrst_urgent got %b want 0", refresh_urgent); end
    endtask

    // pending=3 during cycles 50..57; tick falls in cycle 57 alongside an ack
    task automatic test_tick_and_ack();
        reset_and_release();
        run_to(57);
        vectors++;
        if (pending !== 3'd3) begin miscompares++; $display("FAIL ta_pre_pending got %0d want 3", pending); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors = vectors + 2;
        if (pending !== 3'd3) begin miscompares++; $display("FAIL ta_pending got %0d want 3", pending); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ta_overflow got %b want 0", overflow); end
        // Lone ack in cycle 60 drops to 2, next tick (cycle 65) restores 3
        run_to(60);
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++;
        if (pending !== 3'd2) begin miscompares++; $display("FAIL ack_dec_pending got %0d want 2", pending); end
        run_to(66);
        vectors++;
        if (pending !== 3'd3) begin miscompares++; $display("FAIL ack_after_tick got %0d want 3", pending); end
    endtask

    // Acks during init and at pending=0 in RUN are ignored
    task automatic test_ack_at_zero();
        reset_and_release();
        ack = 1'b1;
        run_to(29);
        ack = 1'b0;
        vectors = vectors + 3;
        if (pending !== 3'd0) begin miscompares++; $display("FAIL zero_pending got %0d want 0", pending); end
        if (refresh_req !== 1'b0) begin miscompares++; $display("FAIL zero_req got %b want 0", refresh_req); end
        if (init_done !== 1'b1) begin miscompares++; $display("FAIL zero_init_done got %b want 1", init_done); end
        run_to(34);
        vectors++;
        if (pending !== 3'd1) begin miscompares++; $display("FAIL zero_first_tick got %0d want 1", pending); end
    endtask

    // Reset mid WAIT_TRFC, then the full timeline must repeat
    task automatic test_mid_reset();
        reset_and_release();
        run_to(15);
        #1 rst_n = 1'b0;
        #1;
        vectors = vectors + 4;
        if (cmd !== 2'b00) begin miscompares++; $display("FAIL midrst_cmd got %b want 00", cmd); end
        if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_cmd_valid got %b want 0", cmd_valid); end
        if (init_done !== 1'b0) begin miscompares++; $display("FAIL midrst_init_done got %b want 0", init_done); end
        if (pending !== 3'd0) begin miscompares++; $display("FAIL midrst_pending got %0d want 0", pending); end
        reset_and_release();
        test_init_sequence(30);
    endtask

    // Random acks against a reference model of the pending/overflow behaviour
    task automatic test_random();
        logic [2:0] m_pend;
        logic       m_ovf;
        logic       a;
        logic       tk;
        logic       a_eff;
        reset_and_release();
        run_to(26);
        m_pend = 3'd0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            vectors = vectors + 4;
            if (pending !== m_pend) begin miscompares++; $display("FAIL rnd_pending cyc %0d got %0d want %0d", cyc, pending, m_pend); end
            if (refresh_req !== (m_pend != 3'd0)) begin miscompares++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, refresh_req, m_pend != 3'd0); end
            if (refresh_urgent !== (m_pend >= 3'd4)) begin miscompares++; $display("FAIL rnd_urgent cyc %0d got %b want %b", cyc, refresh_urgent, m_pend >= 3'd4); end
            if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow cyc %0d got %b want %b", cyc, overflow, m_ovf); end
            // Vary ack density in phases so pending both drains and saturates
            if ((i / 250) % 2 == 0) a = ($urandom_range(0, 11) == 0);
            else                    a = ($urandom_range(0, 4) == 0);
            ack   = a;
            tk    = (((cyc - 26) % 8) == 7);
            a_eff = a && (m_pend != 3'd0);
            if (tk && !a_eff) begin
                if (m_pend == 3'd7) m_ovf = 1'b1;
                else                m_pend = m_pend + 3'd1;
            end else if (a_eff && !tk) begin
                m_pend = m_pend - 3'd1;
            end
            step();
        end
        ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        ack         = 1'b0;
        test_reset();
        reset_and_release();
        test_init_sequence(30);
        test_saturation();
        test_tick_and_ack();
        test_ack_at_zero();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_refresh_scheduler.md
SDRAM_REFRESH_SCHEDULER -- requirements
Module: sdram_refresh_scheduler

Interface
REQ-001 Parameter INIT_CYCLES, default 20000: power-up wait in clocks (200 us at 100 MHz).
REQ-002 Parameter T_RP, default 2: clocks waited after PRECHARGE_ALL.
REQ-003 Parameter T_RFC, default 7: clocks waited after each AUTO_REFRESH.
REQ-004 Parameter T_MRD, default 2: clocks waited after LOAD_MODE.
REQ-005 Parameter INIT_REFRESHES, default 8: AUTO_REFRESH commands issued during init.
REQ-006 Parameter REFRESH_INTERVAL, default 780: clocks between refresh ticks (7.8 us).
REQ-007 Parameter URGENT_LEVEL, default 4: pending count that asserts refresh_urgent.
REQ-008 clock  input  1  system clock; all state changes on the rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 refresh_ack  input  1  controller has issued one AUTO_REFRESH for a pending request.
REQ-011 cmd  output  2  init command: 00 NOP, 01 PRECHARGE_ALL, 10 AUTO_REFRESH, 11 LOAD_MODE.
REQ-012 cmd_valid  output  1  cmd is valid this cycle (one-cycle pulse per command).
REQ-013 init_done  output  1  init sequence complete; stays high until reset.
REQ-014 refresh_req  output  1  at least one refresh is pending.
REQ-015 refresh_urgent  output  1  pending >= URGENT_LEVEL.
REQ-016 pending  output  3  number of outstanding refreshes.
REQ-017 overflow  output  1  sticky flag: a tick was lost because pending was saturated.

Function
REQ-018 Init FSM states SHALL be WAIT_POWERUP -> PRECHARGE -> WAIT_TRP -> REFRESH -> WAIT_TRFC -> (REFRESH again until INIT_REFRESHES issued) -> LOAD_MODE -> WAIT_TMRD -> RUN.
REQ-019 WAIT_POWERUP SHALL last INIT_CYCLES clocks.
REQ-020 Each command state (PRECHARGE, REFRESH, LOAD_MODE) SHALL last exactly 1 clock with cmd_valid=1 and the matching cmd.
REQ-021 Each WAIT_x state SHALL last exactly T_x clocks with cmd=NOP and cmd_valid=0.
REQ-022 init_done SHALL rise on the first RUN cycle.
- Total clocks from reset release = INIT_CYCLES + 1 + T_RP + INIT_REFRESHES*(1+T_RFC) + 1 + T_MRD.
REQ-023 In RUN, a free-running interval counter SHALL pulse a tick every REFRESH_INTERVAL clocks.
- The first tick comes REFRESH_INTERVAL clocks after entering RUN.
REQ-024 Pending counter SHALL update per cycle as follows:
- tick only: +1
- ack only (pending>0): -1
- tick and ack together: unchanged
- no tick, no ack: unchanged
REQ-025 refresh_ack while pending=0, or before init_done, SHALL be ignored.
REQ-026 A tick while pending=7 with no ack SHALL leave pending at 7 and set overflow.
REQ-027 refresh_req SHALL equal (pending != 0).
REQ-028 refresh_urgent SHALL equal (pending >= URGENT_LEVEL).
REQ-029 refresh_req and refresh_urgent SHALL be combinational from the pending register, with no extra latency.
REQ-030 refresh_req, refresh_urgent and pending SHALL stay 0 before init_done.
REQ-031 cmd_valid SHALL stay 0 in RUN.

Reset
REQ-032 While reset=0, all outputs SHALL be forced, asynchronously:
- cmd=00, cmd_valid=0, init_done=0
- refresh_req=0, refresh_urgent=0, pending=0, overflow=0
- FSM in WAIT_POWERUP, all counters cleared.
REQ-033 Reset asserted mid-init or mid-RUN SHALL restart the full init sequence after release.

Structure
REQ-034 The command encodings (NOP, PRECHARGE_ALL, AUTO_REFRESH, LOAD_MODE) SHALL live in the shared SDRAM package.
REQ-035 The FSM state encoding SHALL also live in the shared SDRAM package.
REQ-036 The pending counter SHALL be an instance of sync_parallel_counter, configured as follows:
- size=3, init_value=0
- inc_enable = tick & ~ack
- dec_enable = ack & ~tick
- saturation gating done in this block.

Verification
Bench parameters: INIT_CYCLES=10, T_RP=2, T_RFC=4, T_MRD=2, INIT_REFRESHES=2, REFRESH_INTERVAL=8, URGENT_LEVEL=4.
REQ-037 Release reset, no ack -> the following SHALL be observed:
- cmd_valid pulses at clocks 10 (01), 13 (10), 18 (10) and 23 (11)
- init_done=1 from clock 26.
REQ-038 Run to init_done, no ack -> pending SHALL step 1,2,...,7 every 8 clocks.
- refresh_urgent rises when pending=4.
- The next tick leaves pending=7 and sets overflow=1.
REQ-039 pending=3, tick and refresh_ack in the same cycle -> pending SHALL stay 3 and overflow SHALL stay 0.
REQ-040 pending=0, refresh_ack=1 for 3 clocks -> pending SHALL stay 0 and refresh_req SHALL stay 0.
REQ-041 Assert reset at clock 15 (mid WAIT_TRFC) -> all outputs SHALL be 0 immediately.
- After release, the sequence of REQ-037 SHALL repeat from clock 0.
REQ-042 Random tick/ack stimulus for 1000 cycles SHALL match a reference model of pending, refresh_req, refresh_urgent and overflow every cycle.
